multiplicador_seq_4bits: RTL and testbench

MULTIPLICADOR_SEQ_4BITS -- requirements
Module: multiplicador_seq_4bits

---
 rtl/multiplicador_seq_4bits.sv | 86 ++++++++
 tb/tb_multiplicador_seq_4bits.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq_4bits.sv
// multiplicador_seq_4bits: 4x4 unsigned shift-and-add sequential multiplier
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   A       in   [3:0] multiplicand
//   B       in   [3:0] multiplier
//   Inicio  in   start request, sampled on clk
//   Produto out  [7:0] registered product, held until the next result
//   Pronto  out  one-cycle pulse, Produto valid (state FIM)
//   Ocupado out  high while calculating (state CALCULA)
// Build option MULT_ZERO_RAPIDO_EN: a zero operand skips CALCULA and goes straight to FIM.
module multiplicador_seq_4bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Inicio,
    output logic [7:0] Produto,
    output logic       Pronto,
    output logic       Ocupado
);
    typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;
    estado_t    estado_q, estado_d;
    logic [7:0] mcand_q, mcand_d, acc_q, acc_d, produto_q, produto_d, soma;
    logic [3:0] mplier_q, mplier_d;
    logic [1:0] cnt_q, cnt_d;
    logic       zero_op;
    assign soma = acc_q + (mplier_q[0] ? mcand_q : 8'd0);
`ifdef MULT_ZERO_RAPIDO_EN
    assign zero_op = (A == 4'd0) || (B == 4'd0);
`else
    assign zero_op = 1'b0;
`endif
    always_comb begin
        estado_d  = estado_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        produto_d = produto_q;
        case (estado_q)
            CALCULA: begin
                acc_d    = soma;
                mcand_d  = {mcand_q[6:0], 1'b0};
                mplier_d = {1'b0, mplier_q[3:1]};
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    estado_d  = FIM;
                    produto_d = soma;
                end
            end
            default: begin
                // The edge leaving FIM is the first idle sampling edge, so a held
                // Inicio restarts there and yields one result every 5 cycles.
                if (estado_q != OCIOSO) estado_d = OCIOSO;
                if (Inicio) begin
                    mcand_d  = {4'd0, A};
                    mplier_d = B;
                    acc_d    = 8'd0;
                    cnt_d    = 2'd0;
                    estado_d = zero_op ? FIM : CALCULA;
                    if (zero_op) produto_d = 8'd0;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            mcand_q   <= 8'd0;
            mplier_q  <= 4'd0;
            acc_q     <= 8'd0;
            cnt_q     <= 2'd0;
            produto_q <= 8'd0;
        end else begin
            estado_q  <= estado_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            produto_q <= produto_d;
        end
    end
    assign Produto = produto_q;
    assign Pronto  = (estado_q == FIM);
    assign Ocupado = (estado_q == CALCULA);
endmodule

// File: tb/tb_multiplicador_seq_4bits.sv
// tb_multiplicador_seq_4bits: directed self-checking bench for multiplicador_seq_4bits
module tb_multiplicador_seq_4bits;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic       Inicio = 1'b0;
    logic [7:0] Produto;
    logic       Pronto;
    logic       Ocupado;
    int checks = 0;
    int errors = 0;

    multiplicador_seq_4bits dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Inicio(Inicio),
        .Produto(Produto), .Pronto(Pronto), .Ocupado(Ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and watches Pronto for a bounded window.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
        int n;
        logic [7:0] p;
        n = 0;
        p = 8'hxx;
        A = a;
        B = b;
        Inicio = 1'b1;
        tick();
        Inicio = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (Pronto) begin
                n++;
                p = Produto;
            end
            tick();
        end
        check({tag, "_produto"}, p, exp);
        check({tag, "_pulsos"}, 8'(n), 8'd1);
    endtask

    initial begin
        #2;
        check("rst_produto", Produto, 8'h00);
        check("rst_pronto", {7'd0, Pronto}, 8'd0);
        check("rst_ocupado", {7'd0, Ocupado}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 15*15 with full timing checks
        A = 4'hF; B = 4'hF; Inicio = 1'b1;
        tick();
        Inicio = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ff_ocupado", {7'd0, Ocupado}, 8'd1);
            check("ff_pronto_cedo", {7'd0, Pronto}, 8'd0);
            check("ff_produto_estavel", Produto, 8'h00);
            tick();
        end
        check("ff_pronto", {7'd0, Pronto}, 8'd1);
        check("ff_ocupado_fim", {7'd0, Ocupado}, 8'd0);
        check("ff_produto", Produto, 8'hE1);
        tick();
        check("ff_pronto_pulso", {7'd0, Pronto}, 8'd0);
        tick();
        check("ff_produto_mantido", Produto, 8'hE1);

        // operands latched at E0
        A = 4'd3; B = 4'd5; Inicio = 1'b1;
        tick();
        Inicio = 1'b0; A = 4'd9; B = 4'd9;
        tick(); tick(); tick();
        check("lat_produto_calc", Produto, 8'hE1);
        tick();
        check("lat_pronto", {7'd0, Pronto}, 8'd1);
        check("lat_produto", Produto, 8'h0F);
        tick();

        // zero operand
        A = 4'd0; B = 4'd9; Inicio = 1'b1;
        tick();
        Inicio = 1'b0;
`ifdef MULT_ZERO_RAPIDO_EN
        check("zero_pronto", {7'd0, Pronto}, 8'd1);
        check("zero_ocupado", {7'd0, Ocupado}, 8'd0);
        check("zero_produto", Produto, 8'h00);
        tick();
        check("zero_pronto_fim", {7'd0, Pronto}, 8'd0);
`else
        check("zero_ocupado", {7'd0, Ocupado}, 8'd1);
        check("zero_pronto_cedo", {7'd0, Pronto}, 8'd0);
        tick(); tick(); tick(); tick();
        check("zero_pronto", {7'd0, Pronto}, 8'd1);
        check("zero_produto", Produto, 8'h00);
        tick();
        check("zero_pronto_fim", {7'd0, Pronto}, 8'd0);
`endif
        tick();

        // Inicio held high: results at E4 and E9
        A = 4'd2; B = 4'd7; Inicio = 1'b1;
        tick();
        A = 4'd4; B = 4'd4;
        tick(); tick(); tick();
        check("cont_ocupado", {7'd0, Ocupado}, 8'd1);
        tick();
        check("cont_pronto1", {7'd0, Pronto}, 8'd1);
        check("cont_produto1", Produto, 8'h0E);
        tick();
        check("cont_reinicio", {7'd0, Ocupado}, 8'd1);
        check("cont_pronto_baixo", {7'd0, Pronto}, 8'd0);
        tick(); tick(); tick();
        check("cont_produto_mantido", Produto, 8'h0E);
        tick();
        check("cont_pronto2", {7'd0, Pronto}, 8'd1);
        check("cont_produto2", Produto, 8'h10);
        Inicio = 1'b0;
        tick();
        check("cont_fim_pronto", {7'd0, Pronto}, 8'd0);
        check("cont_fim_ocupado", {7'd0, Ocupado}, 8'd0);

        // reset mid-operation
        A = 4'hF; B = 4'hF; Inicio = 1'b1;
        tick();
        Inicio = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort_produto", Produto, 8'h00);
        check("abort_ocupado", {7'd0, Ocupado}, 8'd0);
        check("abort_pronto", {7'd0, Pronto}, 8'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("abort_sem_pronto", {7'd0, Pronto}, 8'd0);
            tick();
        end
        run_op(4'd6, 4'd7, 8'h2A, "pos_reset");

        // exhaustive sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b), 8'(a * b), "varredura");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
